// File: rtl/nn_pkg.sv
// Shared constants and types for the digit-classifier pipeline: frame geometry,
// network dimensions and the image loader state encoding.
package nn_pkg;

  localparam int NUM_PIXELS_DEFAULT  = 784;
  localparam int PIXEL_SHIFT_DEFAULT = 8;

  localparam int NN_INPUT_SIZE  = 784;
  localparam int NN_HIDDEN_SIZE = 32;
  localparam int NN_OUTPUT_SIZE = 10;

  localparam int PIXEL_W = 8;
  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 32;
  localparam int DIGIT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FLUSH,
    ST_START,
    ST_WAIT_NN,
    ST_RESULT
  } loader_state_t;

  // States in which the loader takes pixels (and honours a frame abort).
  function automatic logic accepts_pixels(input loader_state_t s);
    return (s == ST_IDLE) || (s == ST_LOAD) || (s == ST_RESULT);
  endfunction

endpackage

// File: rtl/image_loader_pixel_formatter.sv
// Converts an unsigned 8-bit pixel into the network's fixed-point input word.
module pixel_formatter
  import nn_pkg::*;
#(
  parameter int PIXEL_SHIFT = PIXEL_SHIFT_DEFAULT
) (
  input  logic        [PIXEL_W-1:0] pixel,
  output logic signed [DATA_W-1:0]  word
);

  assign word = DATA_W'(pixel) << PIXEL_SHIFT;

endmodule

// File: rtl/image_loader.sv
// Streams one frame of pixels into image memory, kicks off inference and
// latches the classified digit until the next frame begins.
module image_loader
  import nn_pkg::*;
#(
  parameter int NUM_PIXELS  = NUM_PIXELS_DEFAULT,
  parameter int PIXEL_SHIFT = PIXEL_SHIFT_DEFAULT
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      pixel_valid,
  input  logic        [PIXEL_W-1:0] pixel_data,
  output logic                      pixel_ready,
  input  logic                      clear,
  output logic        [ADDR_W-1:0]  mem_write_addr,
  output logic signed [DATA_W-1:0]  mem_write_data,
  output logic                      mem_write_enable,
  output logic                      nn_start,
  input  logic                      nn_done,
  input  logic        [DIGIT_W-1:0] nn_argmax,
  output logic        [DIGIT_W-1:0] result_digit,
  output logic                      result_valid,
  output logic                      busy
);

  localparam logic [ADDR_W-1:0] LAST_INDEX = ADDR_W'(NUM_PIXELS - 1);

  loader_state_t            state, next_state;
  logic        [ADDR_W-1:0] pixel_index, index_next, write_addr_now;
  logic                     accept;
  logic signed [DATA_W-1:0] formatted;

  pixel_formatter #(.PIXEL_SHIFT(PIXEL_SHIFT)) u_formatter (
    .pixel (pixel_data),
    .word  (formatted)
  );

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    next_state     = state;
    index_next     = pixel_index;
    accept         = 1'b0;
    // A pixel taken outside LOAD always starts a fresh frame at address 0.
    write_addr_now = (state == ST_LOAD) ? pixel_index : '0;
    unique case (state)
      ST_IDLE, ST_LOAD, ST_RESULT: begin
        if (clear) begin
          next_state = ST_IDLE;
          index_next = '0;
        end else if (pixel_valid && pixel_ready) begin
          accept = 1'b1;
          if (write_addr_now == LAST_INDEX) begin
            next_state = ST_FLUSH;
            index_next = '0;
          end else begin
            next_state = ST_LOAD;
            index_next = write_addr_now + 1'b1;
          end
        end
      end
      ST_FLUSH:   next_state = ST_START;
      ST_START:   next_state = ST_WAIT_NN;
      ST_WAIT_NN: if (nn_done) next_state = ST_RESULT;
      default:    next_state = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the values from before this edge regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      pixel_index <= '0;
      pixel_ready <= 1'b0;
    end else begin
      state       <= next_state;
      pixel_index <= index_next;
      pixel_ready <= accepts_pixels(next_state);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_write_enable <= 1'b0;
      mem_write_addr   <= '0;
      mem_write_data   <= '0;
    end else begin
      mem_write_enable <= accept;
      if (accept) begin
        mem_write_addr <= write_addr_now;
        mem_write_data <= formatted;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      result_valid <= 1'b0;
      result_digit <= '0;
    end else if (state == ST_WAIT_NN && nn_done) begin
      result_valid <= 1'b1;
      result_digit <= nn_argmax;
    end else if (accepts_pixels(state) && (clear || accept)) begin
      result_valid <= 1'b0;
    end
  end

  assign nn_start = (state == ST_START);
  assign busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_image_loader.sv
// Randomized bench for image_loader, checked every cycle against a frame-level
// model built from pixel counts, inference progress and the latched result.
module tb_image_loader;
  import nn_pkg::*;

  localparam int N = 784;

  logic               clk;
  logic               resetn;
  logic               pixel_valid;
  logic [7:0]         pixel_data;
  logic               pixel_ready;
  logic               clear;
  logic [15:0]        mem_write_addr;
  logic signed [31:0] mem_write_data;
  logic               mem_write_enable;
  logic               nn_start;
  logic               nn_done;
  logic [3:0]         nn_argmax;
  logic [3:0]         result_digit;
  logic               result_valid;
  logic               busy;

  image_loader #(.NUM_PIXELS(N), .PIXEL_SHIFT(8)) dut (
    .clk              (clk),
    .resetn           (resetn),
    .pixel_valid      (pixel_valid),
    .pixel_data       (pixel_data),
    .pixel_ready      (pixel_ready),
    .clear            (clear),
    .mem_write_addr   (mem_write_addr),
    .mem_write_data   (mem_write_data),
    .mem_write_enable (mem_write_enable),
    .nn_start         (nn_start),
    .nn_done          (nn_done),
    .nn_argmax        (nn_argmax),
    .result_digit     (result_digit),
    .result_valid     (result_valid),
    .busy             (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Frame-level model: pixels taken this frame, whether inference is running and
  // how many edges since its last pixel, the latched result, and whether the
  // first post-reset edge has happened yet.
  int         m_cnt;
  bit         m_infer;
  int         m_after;
  bit         m_rvalid;
  logic [3:0] m_rdigit;
  bit         m_armed;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_we"},     32'(mem_write_enable), 32'd0);
    check({tag, "_addr"},   32'(mem_write_addr),   32'd0);
    check({tag, "_data"},   mem_write_data,        32'd0);
    check({tag, "_start"},  32'(nn_start),         32'd0);
    check({tag, "_rvalid"}, 32'(result_valid),     32'd0);
    check({tag, "_rdigit"}, 32'(result_digit),     32'd0);
    check({tag, "_busy"},   32'(busy),             32'd0);
    check({tag, "_ready"},  32'(pixel_ready),      32'd0);
  endtask

  task automatic apply_reset(input int cycles);
    resetn = 1'b0;
    #1;
    check_all_zero("reset_async");
    repeat (cycles) begin
      @(posedge clk);
      #1;
      check_all_zero("reset_hold");
    end
    resetn   = 1'b1;
    m_cnt    = 0;
    m_infer  = 0;
    m_after  = 0;
    m_rvalid = 0;
    m_armed  = 0;
  endtask

  // One clock: drive inputs, advance the model, then check everything observable.
  task automatic tick(input bit v, input logic [7:0] d, input bit clr, input bit done,
                      input logic [3:0] am);
    bit          acc;
    bit          done_ok;
    int          exp_addr;
    logic [31:0] exp_data;
    pixel_valid = v;
    pixel_data  = d;
    clear       = clr;
    nn_done     = done;
    nn_argmax   = am;

    acc      = v && m_armed && !m_infer && !clr;
    done_ok  = done && m_infer && (m_after >= 3);
    exp_addr = m_cnt;
    exp_data = 32'(d) * 256;

    if (m_armed && !m_infer && clr) begin
      m_cnt    = 0;
      m_rvalid = 0;
    end
    if (acc) begin
      m_rvalid = 0;
      m_cnt++;
      if (m_cnt == N) begin
        m_infer = 1;
        m_after = 0;
      end
    end
    if (done_ok) begin
      m_infer  = 0;
      m_cnt    = 0;
      m_rvalid = 1;
      m_rdigit = am;
    end
    if (m_infer) m_after++;
    m_armed = 1;

    @(posedge clk);
    #1;
    check("write_enable", 32'(mem_write_enable), 32'(acc));
    if (acc) begin
      check("write_addr", 32'(mem_write_addr), 32'(exp_addr));
      check("write_data", mem_write_data, exp_data);
    end
    check("nn_start", 32'(nn_start), 32'(m_infer && m_after == 2));
    check("pixel_ready", 32'(pixel_ready), 32'(!m_infer));
    check("busy", 32'(busy), 32'(m_infer || m_cnt > 0 || m_rvalid));
    check("result_valid", 32'(result_valid), 32'(m_rvalid));
    if (m_rvalid) check("result_digit", 32'(result_digit), 32'(m_rdigit));
  endtask

  // Offer pixels until the model has taken `target` of this frame.
  task automatic feed(input int target, input int valid_pct, input bit pattern,
                      input bit spurious_done);
    int guard = 0;
    while (m_cnt < target && !m_infer && guard < 20000) begin
      tick($urandom_range(99) < valid_pct,
           pattern ? 8'(m_cnt) : 8'($urandom),
           1'b0,
           spurious_done && ($urandom_range(15) == 0),
           4'($urandom));
      guard++;
    end
    check("feed_progress", 32'(m_cnt >= target || m_infer), 32'd1);
  endtask

  // Run out an inference: `delay` cycles of pressure, then the nn_done pulse.
  task automatic infer(input int delay, input logic [3:0] am, input bit valid_high,
                       input bit clear_high);
    repeat (delay) tick(valid_high, 8'($urandom), clear_high, 1'b0, 4'($urandom));
    tick(valid_high, 8'($urandom), clear_high, 1'b1, am);
  endtask

  initial begin
    pixel_valid = 1'b0;
    pixel_data  = '0;
    clear       = 1'b0;
    nn_done     = 1'b0;
    nn_argmax   = '0;
    m_rdigit    = '0;

    apply_reset(3);
    tick(1'b0, 8'd0, 1'b0, 1'b0, 4'd0);

    // Gap-free frame of i mod 256, then pixel_valid held through inference.
    feed(N, 100, 1'b1, 1'b0);
    infer(5, 4'd7, 1'b1, 1'b0);

    // Result held for 100 cycles while stray nn_done pulses are ignored.
    for (int i = 0; i < 100; i++)
      tick(1'b0, 8'd0, 1'b0, (i % 10) == 3, 4'd3);

    // 50% gaps, random pixels, stray nn_done in LOAD; clear ignored during inference.
    feed(N, 50, 1'b0, 1'b1);
    infer(4, 4'($urandom), 1'b0, 1'b1);
    repeat (5) tick(1'b0, 8'd0, 1'b0, 1'b0, 4'd0);
    tick(1'b0, 8'd0, 1'b1, 1'b0, 4'd0);

    // Abort after 300 pixels with a pixel presented alongside clear, then a full frame.
    feed(300, 70, 1'b0, 1'b0);
    tick(1'b1, 8'hAA, 1'b1, 1'b0, 4'd0);
    feed(N, 50, 1'b0, 1'b0);
    infer(3, 4'd12, 1'b1, 1'b0);
    tick(1'b1, 8'h5C, 1'b0, 1'b0, 4'd0);

    // Reset in the middle of a frame, then restart from address 0.
    feed(400, 80, 1'b0, 1'b0);
    apply_reset(3);
    tick(1'b1, 8'h11, 1'b0, 1'b0, 4'd0);
    feed(10, 100, 1'b0, 1'b0);
    tick(1'b0, 8'd0, 1'b1, 1'b0, 4'd0);
    tick(1'b1, 8'h42, 1'b0, 1'b0, 4'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/image_loader.md
IMAGE_LOADER -- requirements
Module: image_loader

Interface
REQ-001 The block SHALL have parameter NUM_PIXELS, default 784, meaning the number of pixels per frame, which sets the image memory depth.
REQ-002 The block SHALL have parameter PIXEL_SHIFT, default 8, meaning the left shift applied to an 8-bit pixel to form a fixed-point word.
REQ-003 The block SHALL have port clk, input, 1 bit: the clock.
REQ-004 The block SHALL have port resetn, input, 1 bit: reset, asynchronous, active-low; the clock is clk.
REQ-005 The block SHALL have port pixel_valid, input, 1 bit: upstream pixel present.
REQ-006 The block SHALL have port pixel_data, input, 8 bits: unsigned pixel intensity.
REQ-007 The block SHALL have port pixel_ready, output, 1 bit: the block can accept a pixel.
REQ-008 The block SHALL have port clear, input, 1 bit: synchronous frame abort.
REQ-009 The block SHALL have port mem_write_addr, output, 16 bits: image memory write address.
REQ-010 The block SHALL have port mem_write_data, output, 32 bits, signed: image memory write data.
REQ-011 The block SHALL have port mem_write_enable, output, 1 bit: image memory write strobe.
REQ-012 The block SHALL have port nn_start, output, 1 bit: inference start pulse.
REQ-013 The block SHALL have port nn_done, input, 1 bit: inference complete, a 1-cycle pulse.
REQ-014 The block SHALL have port nn_argmax, input, 4 bits: classified digit, valid when nn_done is high.
REQ-015 The block SHALL have port result_digit, output, 4 bits: latched classification.
REQ-016 The block SHALL have port result_valid, output, 1 bit: result_digit holds a valid result.
REQ-017 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-018 The block SHALL implement the states IDLE, LOAD, FLUSH, START, WAIT_NN and RESULT.
REQ-019 A pixel SHALL be accepted only on a cycle where pixel_valid and pixel_ready are both high.
REQ-020 pixel_ready SHALL be high in IDLE, LOAD and RESULT, and low in all other states.
REQ-021 In IDLE or RESULT, an accepted pixel SHALL be written to address 0, clear result_valid, and move the block to LOAD.
REQ-022 Each accepted pixel SHALL produce a write on the next cycle: mem_write_enable=1, mem_write_addr=pixel index, mem_write_data=zero-extended pixel_data<<PIXEL_SHIFT; the latency is one cycle.
REQ-023 Writes SHALL be strictly sequential from 0 to NUM_PIXELS-1, with no address skipped or repeated, and any number of idle cycles allowed between pixels.
REQ-024 Acceptance of pixel NUM_PIXELS-1 SHALL move the block to FLUSH, where the final write occurs and pixel_ready is low.
REQ-025 FLUSH SHALL be followed by START, in which nn_start is high for exactly one cycle.
REQ-026 START SHALL be followed by WAIT_NN; on nn_done, result_digit SHALL be set to nn_argmax, result_valid SHALL be set to 1, and the block SHALL move to RESULT.
REQ-027 result_valid and result_digit SHALL hold in RESULT until the next pixel is accepted or clear is asserted.
REQ-028 In IDLE, LOAD or RESULT, clear SHALL return the block to IDLE, reset the pixel index to 0, and clear result_valid; a pixel presented on the same cycle is dropped and no write occurs.
REQ-029 clear SHALL be ignored in FLUSH, START and WAIT_NN, because inference cannot be aborted.
REQ-030 nn_done SHALL be ignored outside WAIT_NN.
REQ-031 nn_start SHALL never be asserted before all NUM_PIXELS writes have completed.
REQ-032 The pixel index SHALL be 16 bits wide and SHALL be reset to 0 on every frame start.

Reset
REQ-033 While resetn=0, the state SHALL be IDLE and the pixel index 0.
REQ-034 While resetn=0, mem_write_enable, nn_start, result_valid and busy SHALL be 0.
REQ-035 While resetn=0, result_digit, mem_write_addr and mem_write_data SHALL be 0, and pixel_ready SHALL be 0.
REQ-036 On the first clock edge after reset is released, pixel_ready SHALL be 1.
REQ-037 Reset asserted mid-load or mid-inference SHALL abandon the frame, and the partial memory contents SHALL be don't-care.

Structure
REQ-038 The state encodings and the NUM_PIXELS and PIXEL_SHIFT defaults SHALL be placed in the shared nn_pkg package, alongside the network dimension constants.
REQ-039 The block SHALL contain a single sub-module, pixel_formatter (combinational zero-extend and shift), with everything else in a flat FSM plus datapath.

Verification
REQ-040 Scenario: stream 784 pixels with pixel[i]=i mod 256, no gaps -> 784 writes, addr 0..783, data[5]=0x500, data[255]=0xFF00; one nn_start pulse two cycles after the last accept.
REQ-041 Scenario: random pixel_valid gaps (50% duty) -> identical write sequence, no duplicates, and pixel_ready stays high until the 784th accept.
REQ-042 Scenario: in WAIT_NN, pulse nn_done with nn_argmax=7 -> result_digit=7 and result_valid=1 one cycle later, held for 100 cycles; a new pixel then clears result_valid and writes addr 0.
REQ-043 Scenario: assert clear after 300 pixels -> IDLE; the next frame writes from addr 0; clear asserted during WAIT_NN is ignored and the result is still latched.
REQ-044 Scenario: resetn low for 3 cycles at pixel 400 -> all outputs 0 during reset; after release, pixel_ready=1 and the next pixel is written to addr 0.
REQ-045 Scenario: pixel_valid held high during FLUSH, START and WAIT_NN -> no acceptance and no writes; a spurious nn_done in LOAD causes no state change.
